// File: rtl/lcd_bus_receiver.sv
// HD44780-style 8-bit LCD write-bus receiver: strobe decode, command subset, 2x16 buffer, timing checks.
// Pulses one cycle after the EN fall is seen; rd_char one cycle after rd_addr. No backpressure; busy/short violations are flagged.
// Optional busy-flag readback when LCD_RX_BUSY_READ_EN is defined.
module lcd_bus_receiver #(
    parameter int EN_MIN_HIGH       = 20,
    parameter int BUSY_CYCLES       = 1000,
    parameter int CLEAR_BUSY_CYCLES = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ddram_addr,
    output logic       disp_on,
    output logic       entry_inc,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       busy,
    output logic       strobe_valid,
    output logic       strobe_rs,
    output logic [7:0] strobe_byte,
    output logic       err_short,
    output logic       err_busy,
    output logic       err_rw
`ifdef LCD_RX_BUSY_READ_EN
    ,
    output logic [7:0] lcd_dout,
    output logic       lcd_dout_oe
`endif
);

`ifdef LCD_RX_BUSY_READ_EN
    localparam bit BUSY_READ = 1'b1;
`else
    localparam bit BUSY_READ = 1'b0;
`endif

    localparam int CW = $clog2(EN_MIN_HIGH + 1);
    localparam int BW = $clog2(CLEAR_BUSY_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EN_HIGH, EXEC, CLEARING} state_t;
    state_t state, state_nxt;

    logic          en_q, rs_q, rw_q;
    logic [7:0]    data_q;
    logic [CW-1:0] high_cnt;
    logic [CW:0]   high_len;
    logic [BW-1:0] busy_cnt;
    logic          pend;
    logic [4:0]    clr_idx;
    logic [7:0]    mem [32];

    logic       rise, too_short;
    logic       short_c, busyerr_c, rwerr_c, accept_c;
    logic       is_clear, is_home_or_clear;
    logic [7:0] b;
    logic [6:0] step_addr;
    logic       wr_ok;
    logic [4:0] wr_idx;

    assign rise      = lcd_en & ~en_q;
    assign high_len  = {1'b0, high_cnt} + (CW+1)'(1);
    assign too_short = high_len < (CW+1)'(EN_MIN_HIGH);
    assign busy      = |busy_cnt;

    assign b                = strobe_byte;
    assign is_clear         = ~strobe_rs && (b == 8'h01);
    assign is_home_or_clear = ~strobe_rs && (b[7:2] == 6'd0) && (b[1:0] != 2'd0);
    assign step_addr        = entry_inc ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
    // Line 1 lives at 0x00-0x0F, line 2 at 0x40-0x4F; bit 6 picks the line.
    assign wr_ok            = (ddram_addr[5:4] == 2'b00);
    assign wr_idx           = {ddram_addr[6], ddram_addr[3:0]};

    always_comb begin
        state_nxt = state;
        short_c   = 1'b0;
        busyerr_c = 1'b0;
        rwerr_c   = 1'b0;
        accept_c  = 1'b0;
        case (state)
            IDLE:     if (rise || pend) state_nxt = EN_HIGH;
            EN_HIGH: begin
                if (!lcd_en) begin
                    state_nxt = IDLE;
                    if (too_short)                        short_c   = 1'b1;
                    else if (busy && !(BUSY_READ && rw_q)) busyerr_c = 1'b1;
                    else if (rw_q)                         rwerr_c   = !BUSY_READ;
                    else begin
                        accept_c  = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC:     state_nxt = is_clear ? CLEARING : IDLE;
            CLEARING: if (clr_idx == 5'd31) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Bus fields are captured only while EN is high so they hold the last pre-fall values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= 8'd0;
            high_cnt <= '0;
            pend     <= 1'b0;
        end else begin
            en_q <= lcd_en;
            if (lcd_en) begin
                rs_q   <= lcd_rs;
                rw_q   <= lcd_rw;
                data_q <= lcd_data;
            end
            if (rise)
                high_cnt <= '0;
            else if (lcd_en && high_cnt != CW'(EN_MIN_HIGH))
                high_cnt <= high_cnt + 1'b1;
            if (state == IDLE)
                pend <= 1'b0;
            else if (rise && (state == EXEC || state == CLEARING))
                pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_valid <= 1'b0;
            strobe_rs    <= 1'b0;
            strobe_byte  <= 8'd0;
            err_short    <= 1'b0;
            err_busy     <= 1'b0;
            err_rw       <= 1'b0;
            busy_cnt     <= '0;
        end else begin
            strobe_valid <= accept_c;
            err_short    <= short_c;
            err_busy     <= busyerr_c;
            err_rw       <= rwerr_c;
            if (accept_c) begin
                strobe_rs   <= rs_q;
                strobe_byte <= data_q;
            end
            if (state == EXEC)
                busy_cnt <= is_home_or_clear ? BW'(CLEAR_BUSY_CYCLES) : BW'(BUSY_CYCLES);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ddram_addr <= 7'd0;
            disp_on    <= 1'b0;
            entry_inc  <= 1'b1;
            func_8bit  <= 1'b0;
            func_2line <= 1'b0;
            clr_idx    <= 5'd0;
            for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
        end else if (state == EXEC) begin
            clr_idx <= 5'd0;
            if (strobe_rs) begin
                if (wr_ok) mem[wr_idx] <= b;
                ddram_addr <= step_addr;
            end else begin
                casez (b)
                    8'b1???????: ddram_addr <= b[6:0];
                    8'b01??????: ;
                    8'b001?????: begin
                        func_8bit  <= b[4];
                        func_2line <= b[3];
                    end
                    8'b0001????: if (!b[3]) ddram_addr <= b[2] ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
                    8'b00001???: disp_on   <= b[2];
                    8'b000001??: entry_inc <= b[1];
                    8'b0000001?: ddram_addr <= 7'd0;
                    8'b00000001: begin
                        ddram_addr <= 7'd0;
                        entry_inc  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (state == CLEARING) begin
            mem[clr_idx] <= 8'h20;
            clr_idx      <= clr_idx + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_char <= 8'd0;
        else      rd_char <= mem[rd_addr];
    end

`ifdef LCD_RX_BUSY_READ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lcd_dout_oe <= 1'b0;
        else      lcd_dout_oe <= lcd_en && lcd_rw && !lcd_rs && (state == IDLE || state == EN_HIGH);
    end
    assign lcd_dout = lcd_dout_oe ? {busy, ddram_addr} : 8'd0;
`endif

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Synthesizable receiver/model for the HD44780-style 8-bit parallel LCD write bus (signals EN, RS, RW, DATA[7:0]).
- Sits on the far end of the LCD interface in simulation and on-chip self-test. It decodes strobes, executes the command subset, and keeps a 2x16 character buffer that a bench or debug port can read.
- Also enforces the bus timing rules, reporting short EN pulses and writes issued while busy.

Parameters:
- EN_MIN_HIGH, 20: minimum EN-high length, in clk cycles, for a strobe to be valid.
- BUSY_CYCLES, 1000: busy duration after an accepted data write or normal command.
- CLEAR_BUSY_CYCLES, 3000: busy duration after clear (0x01) or return-home (0x02/0x03).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- lcd_data  in  8  LCD data bus.
- lcd_en  in  1  LCD enable strobe.
- lcd_rs  in  1  register select; 0=command, 1=data.
- lcd_rw  in  1  0=write, 1=read.
- rd_addr  in  5  buffer read index; 0-15 = line 1, 16-31 = line 2.
- rd_char  out  8  registered buffer byte at rd_addr; 1-cycle latency.
- ddram_addr  out  7  current address counter.
- disp_on  out  1  display-on bit (D).
- entry_inc  out  1  I/D bit; 1=increment.
- func_8bit  out  1  DL bit.
- func_2line  out  1  N bit.
- busy  out  1  internal busy flag.
- strobe_valid  out  1  1-cycle pulse when a strobe is accepted.
- strobe_rs  out  1  RS of the last accepted strobe.
- strobe_byte  out  8  DATA of the last accepted strobe.
- err_short  out  1  1-cycle pulse: EN high for fewer than EN_MIN_HIGH cycles.
- err_busy  out  1  1-cycle pulse: valid-length strobe ended while busy.
- err_rw  out  1  1-cycle pulse: strobe with RW=1 (feature disabled).

Behaviour:
- Reset: all outputs 0 except entry_inc=1; buffer all 0x20; address 0; state IDLE.
  - rst asserted mid-operation aborts any strobe, clear or busy countdown immediately.
- Input sampling:
  - Inputs are registered once (en_q, rs_q, rw_q, data_q).
  - Rising edge = lcd_en=1 while en_q=0. Falling edge = lcd_en=0 while en_q=1.
- FSM states: IDLE, EN_HIGH, EXEC, CLEARING.
  - IDLE -> EN_HIGH on rising edge; high counter cleared.
  - EN_HIGH counts cycles with EN high. On falling edge, RS/RW/DATA are latched from the cycle before the fall and checked in this order:
    - count < EN_MIN_HIGH: err_short pulse, go IDLE.
    - busy=1: err_busy pulse, go IDLE.
    - RW=1: err_rw pulse, go IDLE.
    - otherwise: strobe_valid pulse, go EXEC.
  - EXEC takes one cycle, executes the strobe, then goes IDLE (or CLEARING for clear).
  - CLEARING writes 0x20 to one buffer entry per cycle, indices 0..31 (32 cycles), then goes IDLE.
  - A rising EN during EXEC/CLEARING is recorded and treated as the start of EN_HIGH once the FSM returns to IDLE; the lost cycles count toward the high length.
- Busy:
  - Loaded in EXEC with BUSY_CYCLES, or CLEAR_BUSY_CYCLES for clear/home.
  - Decrements each cycle; busy=1 while the counter is nonzero. CLEARING always finishes before busy can drop.
- Command decode (RS=0), highest set bit wins:
  - 1AAAAAAA: ddram_addr = AAAAAAA.
  - 01xxxxxx (CGRAM): accepted, no effect.
  - 001DNFxx: func_8bit=D, func_2line=N.
  - 0001SRxx: if S=0, cursor moves (R=1 +1, R=0 -1, mod 128). If S=1, display shift is ignored.
  - 00001DCB: disp_on=D; C and B are ignored.
  - 000001IS: entry_inc=I; S ignored.
  - 0000001x: ddram_addr=0.
  - 00000001: ddram_addr=0, entry_inc=1, then CLEARING.
  - 0x00: no-op; still accepted and busy.
- Data write (RS=1):
  - Address 0x00-0x0F -> index addr. Address 0x40-0x4F -> index 16+(addr-0x40). Any other address: data discarded.
  - The address then steps +1/-1 per entry_inc, wrapping 7-bit (0x7F->0x00, 0x00->0x7F).
- Simultaneous events: an rd_addr read during CLEARING returns the current register contents, with no hazard stall.

Optional Feature:
LCD_RX_BUSY_READ_EN:
- Defined: adds outputs lcd_dout[7:0] and lcd_dout_oe.
  - An RW=1, RS=0 strobe drives lcd_dout={busy,ddram_addr} with oe=1 from the cycle after the rising edge until the falling edge.
  - This strobe is exempt from the busy check and has no other effect.
  - RW=1, RS=1 strobes are ignored with no error.
- Undefined: no extra ports; every RW=1 strobe raises err_rw.

Test Plan:
- Reset, then read all 32 indices -> each rd_char=0x20; entry_inc=1, disp_on=0, busy=0.
- Strobes 0x38, 0x0C, 0x06 (EN high 25 cycles, gaps 3000 cycles) -> func_8bit=1, func_2line=1, disp_on=1, entry_inc=1; no error pulses.
- Data "a","=","1" -> indices 0-2 = 0x61, 0x3D, 0x31; ddram_addr=3. Then command 0xC0 plus data "r" -> index 16=0x72; ddram_addr=0x41.
- EN high 10 cycles -> err_short pulse, buffer unchanged. Valid strobe 100 cycles after the previous one -> err_busy pulse, data not stored.
- Fill buffer, send 0x01 -> 32 CLEARING cycles; all entries 0x20; ddram_addr=0; busy held 3000 cycles.
- entry_inc=0 (0x04), ddram_addr=0x00, write "x" -> index 0=0x78, ddram_addr=0x7F. Strobe with RW=1 -> err_rw pulse (feature off).
